// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO read-side arbiter.
//   state_e  - output register state (IDLE = empty, HOLD = holds a word)
//   CNT_W    - width of the optional per-source grant counters
//   CNT_MAX  - saturation value of those counters
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
//   req        in  NUM_SRC  request vector
//   last_grant in  IDX_W    index granted most recently
//   gnt_valid  out 1        at least one request present
//   gnt        out IDX_W    first requesting index after last_grant, wrapping
module rr_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt
);

    int unsigned idx;

    // Scan the sources starting one past the last winner; the first hit wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = (32'(last_grant) + k) % NUM_SRC;
            if (!gnt_valid && req[IDX_W'(idx)]) begin
                gnt_valid = 1'b1;
                gnt       = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin arbiter draining NUM_SRC show-ahead FIFO read
// sides into one registered valid/ready output.
//   rd_clk     in  1                  clock, all logic on posedge
//   rd_rst     in  1                  synchronous active-high reset
//   rd_empty   in  NUM_SRC            per-source FIFO empty flags
//   rd_data    in  NUM_SRC*DATA_SIZE  per-source head words
//   rd_inc     out NUM_SRC            per-source pop strobe (one-hot or zero)
//   out_valid  out 1                  out_data holds a word
//   out_ready  in  1                  downstream accepts on valid & ready
//   out_data   out DATA_SIZE          granted word
//   out_src    out $clog2(NUM_SRC)    source index of out_data
//   grant_cnt  out NUM_SRC*16         saturating per-source pop counters
//                                     (only when FIFO_ARB_CNT_EN is defined)
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned DATA_SIZE = 8
) (
    input  logic                           rd_clk,
    input  logic                           rd_rst,
    input  logic [NUM_SRC-1:0]             rd_empty,
    input  logic [NUM_SRC*DATA_SIZE-1:0]   rd_data,
    output logic [NUM_SRC-1:0]             rd_inc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_SIZE-1:0]           out_data,
    output logic [$clog2(NUM_SRC)-1:0]     out_src
`ifdef FIFO_ARB_CNT_EN
    ,
    output logic [NUM_SRC*CNT_W-1:0]       grant_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    state_e               state_q, state_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [IDX_W-1:0]     src_q, src_d;
    logic [IDX_W-1:0]     last_q, last_d;

    logic             can_load;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt;
    logic             grant_fire;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (~rd_empty),
        .last_grant (last_q),
        .gnt_valid  (gnt_valid),
        .gnt        (gnt)
    );

    assign out_valid = (state_q == HOLD);
    assign out_data  = data_q;
    assign out_src   = src_q;

    // Loading is allowed when the register is empty or is being drained this
    // cycle, which gives back-to-back words with no bubble.
    assign can_load   = (state_q == IDLE) || (out_valid && out_ready);
    // No pop may happen while reset is asserted: the word would be lost.
    assign grant_fire = can_load && gnt_valid && !rd_rst;

    always_comb begin
        rd_inc = '0;
        if (grant_fire) begin
            rd_inc[gnt] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        if (grant_fire) begin
            state_d = HOLD;
            data_d  = rd_data[32'(gnt)*DATA_SIZE +: DATA_SIZE];
            src_d   = gnt;
            last_d  = gnt;
        end else if (out_valid && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            src_q   <= '0;
            // Pointing at the last source makes source 0 win first.
            last_q  <= IDX_W'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

`ifdef FIFO_ARB_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_SRC];

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (rd_inc[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: self-checking bench for fifo_rd_arbiter (NUM_SRC=4,
// DATA_SIZE=8). Each source is a queue of words; a cycle-level model tracks the
// held output word and the round-robin pointer.
module tb_fifo_rd_arbiter;

    localparam int N = 4;

    logic         rd_clk = 1'b0;
    logic         rd_rst = 1'b0;
    logic [N-1:0] rd_empty = '1;
    logic [N*8-1:0] rd_data = '0;
    logic [N-1:0] rd_inc;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_data;
    logic [1:0]   out_src;
`ifdef FIFO_ARB_CNT_EN
    logic [N*16-1:0] grant_cnt;
`endif

    fifo_rd_arbiter #(
        .NUM_SRC   (N),
        .DATA_SIZE (8)
    ) dut (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .rd_empty  (rd_empty),
        .rd_data   (rd_data),
        .rd_inc    (rd_inc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
`ifdef FIFO_ARB_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    typedef logic [7:0] byte_q_t[$];
    byte_q_t srcq [N];    // words still inside each source FIFO
    byte_q_t sentq [N];   // words popped and not yet accepted downstream

    int         errors = 0;
    int         checks = 0;
    bit         m_known = 1'b0;
    bit         m_valid = 1'b0;
    logic [7:0] m_data = '0;
    int         m_src = 0;
    int         m_last = N - 1;
    int         last_g = -1;
    logic [N-1:0] stall = '0;

    function automatic int next_grant(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            rd_empty[i] = (srcq[i].size() == 0) || stall[i];
            rd_data[i*8 +: 8] = (srcq[i].size() != 0) ? srcq[i][0] : 8'($urandom);
        end
    endtask

    // One clock: drive, check against the model, advance the model on the edge.
    task automatic cycle();
        logic [N-1:0] exp_inc;
        bit can;
        int g;
        drive();
        #1;
        can = !m_valid || out_ready;
        g = next_grant(~rd_empty, m_last);
        exp_inc = (rd_rst || !can || g < 0) ? '0 : (N'(1) << g);
        checks++;
        if (rd_inc !== exp_inc) begin
            errors++;
            $display("FAIL rd_inc: got %b want %b", rd_inc, exp_inc);
        end
        checks++;
        if ((rd_inc & rd_empty) !== '0) begin
            errors++;
            $display("FAIL pop_on_empty: rd_inc %b rd_empty %b", rd_inc, rd_empty);
        end
        if (m_known) begin
            checks++;
            if (out_valid !== m_valid ||
                (m_valid && (out_data !== m_data || out_src !== 2'(m_src)))) begin
                errors++;
                $display("FAIL out_regs: got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                         out_valid, out_data, out_src, m_valid, m_data, m_src);
            end
            if (!rd_rst && m_valid && out_ready) begin
                checks++;
                if (sentq[m_src].size() == 0 || out_data !== sentq[m_src][0]) begin
                    errors++;
                    $display("FAIL scoreboard src%0d: got %h want %h", m_src, out_data,
                             sentq[m_src].size() != 0 ? sentq[m_src][0] : 8'hxx);
                end
                if (sentq[m_src].size() != 0) void'(sentq[m_src].pop_front());
            end
        end
        @(posedge rd_clk);
        last_g = -1;
        if (rd_rst) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_last  = N - 1;
            for (int i = 0; i < N; i++) sentq[i].delete();
        end else if (exp_inc != '0) begin
            m_data  = srcq[g].pop_front();
            sentq[g].push_back(m_data);
            m_src   = g;
            m_last  = g;
            m_valid = 1'b1;
            last_g  = g;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) srcq[i].delete();
        stall = '0;
    endtask

    task automatic do_reset();
        rd_rst = 1'b1;
        cycle();
        rd_rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_sources();
        out_ready = 1'b0;
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_vals: v=%b d=%h s=%0d want 0/00/0", out_valid, out_data, out_src);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) cycle();
    endtask

    task automatic test_round_robin();
        clear_sources();
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 5; j++) srcq[i].push_back(8'((i << 4) | j));
        end
        for (int k = 0; k < 12; k++) begin
            cycle();
            checks++;
            if (last_g != k % N) begin
                errors++;
                $display("FAIL rr_order step %0d: got %0d want %0d", k, last_g, k % N);
            end
        end
    endtask

    task automatic test_hold();
        int pops;
        clear_sources();
        out_ready = 1'b0;
        do_reset();
        srcq[2].push_back(8'hA5);
        pops = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (last_g >= 0) pops++;
        end
        checks++;
        if (pops != 1 || out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2) begin
            errors++;
            $display("FAIL hold: pops=%0d v=%b d=%h s=%0d want 1/1/a5/2",
                     pops, out_valid, out_data, out_src);
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_drain: out_valid=%b want 0", out_valid);
        end
        cycle();
    endtask

    task automatic test_reset_mid();
        clear_sources();
        out_ready = 1'b0;
        do_reset();
        srcq[3].push_back(8'h3C);
        for (int k = 0; k < 3; k++) cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            errors++;
            $display("FAIL pre_reset_hold: v=%b d=%h want 1/3c", out_valid, out_data);
        end
        for (int i = 0; i < N; i++) srcq[i].push_back(8'h50 + 8'(i));
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: out_valid=%b want 0", out_valid);
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (last_g != 0) begin
            errors++;
            $display("FAIL post_reset_grant: got %0d want 0", last_g);
        end
        for (int k = 0; k < 6; k++) cycle();
    endtask

    task automatic test_random();
        bit drained;
        clear_sources();
        out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0 && srcq[i].size() < 8)
                    srcq[i].push_back(8'($urandom));
            end
            stall = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        stall = '0;
        out_ready = 1'b1;
        drained = 1'b0;
        for (int k = 0; k < 100 && !drained; k++) begin
            cycle();
            drained = !m_valid;
            for (int i = 0; i < N; i++) if (srcq[i].size() != 0) drained = 1'b0;
        end
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL drain_timeout: sources not emptied within 100 cycles");
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (sentq[i].size() != 0) begin
                errors++;
                $display("FAIL lost_words src%0d: %0d outstanding want 0", i, sentq[i].size());
            end
        end
    endtask

`ifdef FIFO_ARB_CNT_EN
    task automatic test_grant_cnt();
        clear_sources();
        out_ready = 1'b1;
        do_reset();
        rd_empty = 4'b1101;
        for (int k = 0; k < 70000; k++) @(posedge rd_clk);
        #1;
        rd_empty = '1;
        for (int i = 0; i < N; i++) begin
            logic [15:0] want;
            want = (i == 1) ? 16'hFFFF : 16'h0000;
            checks++;
            if (grant_cnt[i*16 +: 16] !== want) begin
                errors++;
                $display("FAIL grant_cnt[%0d]: got %h want %h", i, grant_cnt[i*16 +: 16], want);
            end
        end
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_round_robin();
        test_hold();
        test_reset_mid();
        test_random();
`ifdef FIFO_ARB_CNT_EN
        test_grant_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
